run_detector: RTL and testbench
===============================

# run_detector

Parametrised run-length detector. It asserts an output once RUN_LEN consecutive enabled samples of input `w` equal a selectable match value. This is the general-purpose successor of the team's fixed two-in-a-row sequence FSM. It adds a configurable run length, a selectable match polarity, overlapping or restart detection, a sample enable, a completion pulse, and an optional detection counter. It sits next to control FSMs that need debounced or qualified level detection.

## Interface
- RUN_LEN, 2, required run length; legal range is ≥1.
- HIT_W, 8, width of the detection counter; only used with the macro.
- CNT_W, local, $clog2(RUN_LEN+1); width of the run counter.

- clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- en  in  1  sample enable; `w` is evaluated only on edges where en=1.
- w  in  1  serial data input.
- match  in  1  value being counted; 1 counts ones, 0 counts zeros.
- restart  in  1  0 = overlapping/saturating detection; 1 = non-overlapping, a new run starts after each detection.
- z  out  1  Moore output; high while the state is DETECT.
- z_pulse  out  1  one-cycle strobe, registered, for each completed run.
- run_cnt  out  CNT_W  current run length, saturating at RUN_LEN.
- hits  out  HIT_W  number of completed runs, saturating; present only with RUN_DET_HITS_EN.

## Operation
- States are S_IDLE (cnt=0), S_COUNT (0<cnt<RUN_LEN) and S_DETECT (cnt=RUN_LEN).
- A hit is a sample with `w==match`. A miss is a sample with `w!=match`.
- en=1 and a miss: go to S_IDLE with cnt=0 from any state.
- en=1 and a hit, from S_IDLE or S_COUNT: cnt+1. Go to S_DETECT when cnt reaches RUN_LEN, otherwise to S_COUNT.
  - With RUN_LEN=1, a hit from S_IDLE goes straight to S_DETECT.
- en=1 and a hit, in S_DETECT:
  - restart=0: stay in S_DETECT and hold cnt=RUN_LEN. No new pulse.
  - restart=1: cnt=1 and go to S_COUNT. With RUN_LEN=1, stay in S_DETECT and generate a new pulse.
- en=0: state, cnt and hits hold. z_pulse goes 0.
- `match` and `restart` are read every sample and have no latching. A change of `match` mid-run applies to the next sample; the run is not cleared.
- z_pulse=1 for the cycle after each edge that completes a run, meaning the next-state computation reaches cnt=RUN_LEN from cnt=RUN_LEN-1 (or from S_DETECT when RUN_LEN=1 and restart=1).
- Arithmetic is unsigned. cnt never exceeds RUN_LEN. hits saturates at 2^HIT_W-1 and never wraps.

## Timing
- Reset has priority over en. All outputs are 0 in the cycle after Reset is sampled high: state S_IDLE, z=0, z_pulse=0, run_cnt=0, hits=0.
- With Reset held high, no hits count regardless of `w`.
- Latency: z and z_pulse rise in the cycle following the edge that samples the RUN_LEN-th consecutive hit.
- z falls in the cycle after the first miss.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- RUN_DET_HITS_EN defined: the `hits` port and its saturating counter are present. The counter increments on every z_pulse.
- RUN_DET_HITS_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `run_det_pkg`: the `state_t` enum (S_IDLE, S_COUNT, S_DETECT) and a helper function computing CNT_W.
- Sub-module `run_sat_counter`: a generic saturating up-counter with sync reset, increment and width parameter. It implements `hits` and is reused for `run_cnt`.

## Test plan
- RUN_LEN=2, match=1, restart=0, en=1, w=0,1,1,1,0 on edges e1–e5 -> z=1 after e3 and e4, z=0 after e5. z_pulse only after e3. run_cnt is 0,1,2,2,0.
- RUN_LEN=3, restart=1, w=1 for 6 edges -> z_pulse after e3 and e6. z high after e3, low after e4–e5, high after e6.
- RUN_LEN=2, match=0, w=0,0,1 -> z=1 after e2, z=0 after e3. z stays 0 when the same stream is run with match=1.
- RUN_LEN=3, w=1 with en=1,0,0,1,1 -> run_cnt is 1,1,1,2,3. z rises after the 5th edge only.
- Reset asserted mid-run at cnt=2 with w=1, en=1 -> run_cnt=0 and z=0 next cycle. Counting restarts from 1 after Reset drops.
- RUN_DET_HITS_EN, HIT_W=2, RUN_LEN=1, restart=1, w=1 for 5 edges -> hits is 1,2,3,3,3.

Source files
------------

// File: rtl/run_det_pkg.sv
// Shared types and helpers for the run-length detector.
// State encoding and run-counter width derivation.
package run_det_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COUNT  = 2'd1,
      S_DETECT = 2'd2
   } state_t;

   // Bits needed to hold 0..run_len inclusive.
   function automatic int run_cnt_width(input int run_len);
      return $clog2(run_len + 1);
   endfunction

endpackage

// File: rtl/run_sat_counter.sv
// Generic saturating up-counter with sync reset, clear and increment.
// clr together with inc loads 1, so a run can restart on the same sample.
module run_sat_counter #(
   parameter int           W   = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = inc ? W'(1) : '0;
      end else if (inc && (q_q != MAX)) begin
         q_d = q_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/run_detector.sv
// Run-length detector: z rises once RUN_LEN consecutive enabled samples of w equal match.
// Optional saturating detection counter on port hits when RUN_DET_HITS_EN is defined.
//
// state    | meaning
// S_IDLE   | no current run (run_cnt = 0)
// S_COUNT  | run in progress (0 < run_cnt < RUN_LEN)
// S_DETECT | run complete (run_cnt = RUN_LEN), z high
module run_detector
   import run_det_pkg::*;
#(
   parameter  int RUN_LEN = 2,
   parameter  int HIT_W   = 8,
   localparam int CNT_W   = run_cnt_width(RUN_LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             w,
   input  logic             match,
   input  logic             restart,
   output logic             z,
   output logic             z_pulse,
`ifdef RUN_DET_HITS_EN
   output logic [HIT_W-1:0] hits,
`endif
   output logic [CNT_W-1:0] run_cnt
);

   localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(RUN_LEN);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(RUN_LEN - 1);
   localparam bit               LEN_ONE = (RUN_LEN == 1);

   if (RUN_LEN < 1) begin : g_bad_run_len
      $error("run_detector: RUN_LEN must be at least 1");
   end
   if (HIT_W < 1) begin : g_bad_hit_w
      $error("run_detector: HIT_W must be at least 1");
   end

   state_t state_q, state_d;
   logic   z_pulse_q, z_pulse_d;
   logic   cnt_clr, cnt_inc;
   logic   hit;

   assign hit = (w == match);

   always_comb begin
      state_d   = state_q;
      z_pulse_d = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      if (en) begin
         if (!hit) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
         end else begin
            cnt_inc = 1'b1;
            case (state_q)
               S_DETECT: begin
                  // Non-overlapping mode: this hit becomes the first of a new run.
                  if (restart) begin
                     cnt_clr = 1'b1;
                     if (LEN_ONE) begin
                        state_d   = S_DETECT;
                        z_pulse_d = 1'b1;
                     end else begin
                        state_d = S_COUNT;
                     end
                  end
               end
               default: begin
                  if (run_cnt == LAST_C) begin
                     state_d   = S_DETECT;
                     z_pulse_d = 1'b1;
                  end else begin
                     state_d = S_COUNT;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         z_pulse_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         z_pulse_q <= z_pulse_d;
      end
   end

   run_sat_counter #(
      .W   (CNT_W),
      .MAX (LEN_C)
   ) u_run_cnt (
      .clk (clk),
      .rst (reset),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .q   (run_cnt)
   );

`ifdef RUN_DET_HITS_EN
   run_sat_counter #(
      .W (HIT_W)
   ) u_hits (
      .clk (clk),
      .rst (reset),
      .clr (1'b0),
      .inc (z_pulse_d),
      .q   (hits)
   );
`endif

   assign z       = (state_q == S_DETECT);
   assign z_pulse = z_pulse_q;

endmodule

// File: tb/tb_run_detector.sv
// Scoreboard bench for run_detector: three instances (RUN_LEN 1, 2, 3) share one
// randomized stimulus stream; a run-length model predicts outputs for each.
module tb_run_detector;

   logic clk;
   logic reset, en, w, match, restart;

   logic       z1, z2, z3;
   logic       p1, p2, p3;
   logic [0:0] c1;
   logic [1:0] c2, c3;
`ifdef RUN_DET_HITS_EN
   logic [1:0] h1, h2, h3;
`endif

   run_detector #(.RUN_LEN(1), .HIT_W(2)) dut1 (
      .clk(clk), .reset(reset), .en(en), .w(w), .match(match), .restart(restart),
      .z(z1), .z_pulse(p1),
`ifdef RUN_DET_HITS_EN
      .hits(h1),
`endif
      .run_cnt(c1));

   run_detector #(.RUN_LEN(2), .HIT_W(2)) dut2 (
      .clk(clk), .reset(reset), .en(en), .w(w), .match(match), .restart(restart),
      .z(z2), .z_pulse(p2),
`ifdef RUN_DET_HITS_EN
      .hits(h2),
`endif
      .run_cnt(c2));

   run_detector #(.RUN_LEN(3), .HIT_W(2)) dut3 (
      .clk(clk), .reset(reset), .en(en), .w(w), .match(match), .restart(restart),
      .z(z3), .z_pulse(p3),
`ifdef RUN_DET_HITS_EN
      .hits(h3),
`endif
      .run_cnt(c3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      bit [2:0] z;
      bit [2:0] p;
      bit [5:0] c;
      bit [5:0] h;
   } exp_t;

   exp_t exp_q[$];
   int   total_checks = 0;
   int   passed_checks = 0;

   // Model: length of the current qualifying run and number of completed runs.
   int run_len_m[3];
   int hits_m[3];

   task automatic chk(input string name, input int act, input int exp);
      total_checks++;
      if (act == exp) passed_checks++;
      else $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
   endtask

   task automatic step(input bit rst_i, input bit en_i, input bit w_i,
                       input bit m_i, input bit rs_i);
      exp_t e;
      @(negedge clk);
      reset = rst_i; en = en_i; w = w_i; match = m_i; restart = rs_i;
      e = '0;
      for (int i = 0; i < 3; i++) begin
         int  len;
         int  nr;
         bit  pl;
         len = i + 1;
         pl  = 1'b0;
         if (rst_i) begin
            run_len_m[i] = 0;
            hits_m[i]    = 0;
         end else if (en_i) begin
            if (w_i != m_i) begin
               run_len_m[i] = 0;
            end else begin
               if (run_len_m[i] == len) nr = rs_i ? 1 : len;
               else                     nr = run_len_m[i] + 1;
               // A run completes when the new length reaches len, unless we were
               // already complete and simply holding there.
               pl = (nr == len) && !((run_len_m[i] == len) && !rs_i);
               run_len_m[i] = nr;
               if (pl && hits_m[i] < 3) hits_m[i]++;
            end
         end
         e.z[i]       = (run_len_m[i] == len);
         e.p[i]       = pl;
         e.c[i*2 +: 2] = 2'(run_len_m[i]);
         e.h[i*2 +: 2] = 2'(hits_m[i]);
      end
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("z_len1", int'(z1), int'(e.z[0]));
         chk("z_len2", int'(z2), int'(e.z[1]));
         chk("z_len3", int'(z3), int'(e.z[2]));
         chk("pulse_len1", int'(p1), int'(e.p[0]));
         chk("pulse_len2", int'(p2), int'(e.p[1]));
         chk("pulse_len3", int'(p3), int'(e.p[2]));
         chk("run_cnt_len1", int'(c1), int'(e.c[1:0]));
         chk("run_cnt_len2", int'(c2), int'(e.c[3:2]));
         chk("run_cnt_len3", int'(c3), int'(e.c[5:4]));
`ifdef RUN_DET_HITS_EN
         chk("hits_len1", int'(h1), int'(e.h[1:0]));
         chk("hits_len2", int'(h2), int'(e.h[3:2]));
         chk("hits_len3", int'(h3), int'(e.h[5:4]));
`endif
      end
   end

   initial begin
      reset = 1'b1; en = 1'b0; w = 1'b0; match = 1'b1; restart = 1'b0;
      for (int i = 0; i < 3; i++) begin run_len_m[i] = 0; hits_m[i] = 0; end

      // Reset with w high and enabled: nothing may count.
      step(1, 1, 1, 1, 0);
      step(1, 1, 1, 1, 0);

      // Overlapping detection: w = 0,1,1,1,0.
      step(0, 1, 0, 1, 0);
      step(0, 1, 1, 1, 0);
      step(0, 1, 1, 1, 0);
      step(0, 1, 1, 1, 0);
      step(0, 1, 0, 1, 0);

      // Restart mode: six ones in a row.
      for (int k = 0; k < 6; k++) step(0, 1, 1, 1, 1);
      step(0, 1, 0, 1, 1);

      // Counting zeros, then the same stream counting ones.
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 1, 1, 1, 0);
      step(0, 1, 0, 1, 0);

      // Enable gaps hold the run.
      step(0, 1, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 1, 1, 1, 0);
      step(0, 1, 1, 1, 0);
      step(0, 1, 0, 1, 0);

      // Reset mid-run, then counting resumes from 1.
      step(0, 1, 1, 1, 0);
      step(0, 1, 1, 1, 0);
      step(1, 1, 1, 1, 0);
      step(0, 1, 1, 1, 0);
      step(0, 1, 1, 1, 0);

      // Saturating hits: long restart run.
      for (int k = 0; k < 8; k++) step(0, 1, 1, 1, 1);

      // Randomized traffic.
      for (int k = 0; k < 500; k++) begin
         bit r_rst, r_en, r_w, r_m, r_rs;
         r_rst = ($urandom_range(0, 39) == 0);
         r_en  = ($urandom_range(0, 9) < 8);
         r_w   = ($urandom_range(0, 9) < 7);
         r_m   = ($urandom_range(0, 9) < 8);
         r_rs  = $urandom_range(0, 1) != 0;
         step(r_rst, r_en, r_w, r_m, r_rs);
      end

      for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
